scoreboard_register_file: RTL
=============================

Name: scoreboard_register_file

Overview:
Next-generation general-purpose register file for the CPU datapath. It has parametrised read and write port counts, an optional hardwired zero register, and optional write-to-read bypass. Per-register busy bits form a scoreboard for multi-cycle producers. A sequential clear engine zeroes the whole array on request, for context reset and debug.

Parameters:
DataWidth, 16, register width in bits
NumRegs, 16, number of registers (power of 2, >= 4)
NumReadPorts, 2, combinational read ports
NumWritePorts, 2, synchronous write ports
ZeroReg, 1, when 1 register 0 always reads 0, ignores writes and is never busy
BypassEn, 1, when 1 same-cycle write data is forwarded to matching reads
IndexWidth, $clog2(NumRegs), register index width (derived)

Ports:
clk  input  1  system clock, rising edge
rstN  input  1  reset; one clock; reset is asynchronous and active-low
writeEn  input  [NumWritePorts]  per-port write enable
writeAddr  input  [NumWritePorts][IndexWidth]  write index
writeData  input  [NumWritePorts][DataWidth]  write data
writeRelease  input  [NumWritePorts]  with writeEn, clears busy bit of writeAddr
readAddr  input  [NumReadPorts][IndexWidth]  read index
readData  output  [NumReadPorts][DataWidth]  read data
readBusy  output  [NumReadPorts]  busy bit of readAddr
reserveEn  input  1  mark a register busy (issue of multi-cycle op)
reserveAddr  input  IndexWidth  register to reserve
clearReq  input  1  start clear sweep (pulse)
clearBusy  output  1  high while sweep active
clearDone  output  1  one-cycle pulse after last register cleared

Behaviour:
- Reset (rstN=0, async): all registers = 0, all busy bits = 0, FSM = IDLE, sweep counter = 0, clearBusy = 0, clearDone = 0. readData = 0 and readBusy = 0 while in reset.
- Writes: take effect on the rising edge when writeEn[i]=1.
- Write conflict: on a same-address conflict the highest-numbered port wins, both for data and for release.
- ZeroReg=1: writes to index 0 are dropped, reserves of index 0 are dropped, reads of index 0 return 0 and busy 0.
- Reads: combinational, 0-cycle latency.
- BypassEn=1: if any enabled write port targets readAddr[j] this cycle, readData[j] = writeData of the highest matching port. If that port also has writeRelease set, readBusy[j] = 0.
- BypassEn=0: read returns pre-edge contents; the new value is visible the cycle after the edge.
- Scoreboard: reserveEn sets busy[reserveAddr] at the edge. Write with writeRelease clears busy[writeAddr] at the edge. Reserve and release of the same register in the same cycle: reserve wins (busy=1). Write without release leaves busy unchanged.
- Clear FSM states:
  - IDLE: clearReq=1 -> SWEEP, counter=0, clearBusy=1 from next cycle.
  - SWEEP: each cycle zeroes regs[counter] and busy[counter], counter++. At counter=NumRegs-1 -> DONE.
  - DONE: clearDone=1 for one cycle, clearBusy=0 -> IDLE.
  - Total: NumRegs cycles in SWEEP.
- During SWEEP/DONE: write ports and reserveEn are ignored (no effect, no bypass). Reads return current array contents. clearReq is ignored.
- Counter wraps naturally only via the DONE transition; no overrun.
- rstN asserted mid-sweep: immediate return to IDLE with the full reset state; no clearDone pulse.

Decomposition:
- Package rf_pkg: clear FSM state enum (IDLE, SWEEP, DONE) and a function computing the highest-priority write-port match for a given index.
- Sub-module rf_clear_ctrl (FSM + counter), outputs sweep index, sweep-active, clearBusy, clearDone.
- Array, scoreboard and bypass muxing stay in the top.

Test Plan:
- Reset then read all indices -> readData=0, readBusy=0; write port0 reg3=0x1234 -> readData reads 0x1234 in same cycle (bypass) and stays 0x1234 next cycle.
- Both ports write reg5 (0x1111 port0, 0x2222 port1) -> reg5=0x2222; write reg0=0xFFFF with ZeroReg=1 -> reads 0.
- reserveEn reg7 -> readBusy=1 next cycle; write reg7=0xBEEF with writeRelease -> same-cycle readBusy=0, readData=0xBEEF; reserve and release reg7 together -> busy stays 1.
- Fill regs 1..15 with nonzero, pulse clearReq -> clearBusy high 16 cycles, clearDone one pulse, all reads 0. A write issued mid-sweep has no effect.
- Assert rstN low at sweep cycle 5 -> clearBusy=0 immediately, no clearDone, all regs 0.
- BypassEn=0 build: write reg2=0x00AA -> same-cycle read shows old value 0, next cycle 0x00AA.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and helpers for the scoreboard register file.
package rf_pkg;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} clr_state_e;

  // Widest write-port count the priority helper can arbitrate.
  localparam int MaxWritePorts = 8;

  // Keeps only the highest-numbered set bit of a write-port hit mask.
  function automatic logic [MaxWritePorts-1:0] win_port(input logic [MaxWritePorts-1:0] hit);
    logic found;
    win_port = '0;
    found    = 1'b0;
    for (int p = MaxWritePorts - 1; p >= 0; p--) begin
      if (hit[p] && !found) begin
        win_port[p] = 1'b1;
        found       = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rf_clear_ctrl.sv
// Clear engine: walks every register index once, then pulses done.
module rf_clear_ctrl
  import rf_pkg::*;
#(
  parameter int NumRegs    = 16,
  parameter int IndexWidth = $clog2(NumRegs)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_req_i,
  output logic [IndexWidth-1:0] sweep_idx_o,
  output logic                  sweep_o,
  output logic                  clear_busy_o,
  output logic                  clear_done_o
);

  clr_state_e            state_q, state_d;
  logic [IndexWidth-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear_req_i) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IndexWidth'(NumRegs - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sweep_idx_o  = cnt_q;
  assign sweep_o      = (state_q == SWEEP);
  assign clear_busy_o = (state_q == SWEEP);
  assign clear_done_o = (state_q == DONE);

endmodule

// File: rtl/scoreboard_register_file.sv
// Multi-port register file with busy-bit scoreboard, write bypass and clear sweep.
module scoreboard_register_file
  import rf_pkg::*;
#(
  parameter int DataWidth     = 16,
  parameter int NumRegs       = 16,
  parameter int NumReadPorts  = 2,
  parameter int NumWritePorts = 2,
  parameter int ZeroReg       = 1,
  parameter int BypassEn      = 1,
  parameter int IndexWidth    = $clog2(NumRegs)
) (
  input  logic                                    clk,
  input  logic                                    rstN,
  input  logic [NumWritePorts-1:0]                writeEn,
  input  logic [NumWritePorts-1:0][IndexWidth-1:0] writeAddr,
  input  logic [NumWritePorts-1:0][DataWidth-1:0]  writeData,
  input  logic [NumWritePorts-1:0]                writeRelease,
  input  logic [NumReadPorts-1:0][IndexWidth-1:0]  readAddr,
  output logic [NumReadPorts-1:0][DataWidth-1:0]   readData,
  output logic [NumReadPorts-1:0]                 readBusy,
  input  logic                                    reserveEn,
  input  logic [IndexWidth-1:0]                   reserveAddr,
  input  logic                                    clearReq,
  output logic                                    clearBusy,
  output logic                                    clearDone
);

  logic [NumRegs-1:0][DataWidth-1:0] regs_q, regs_d;
  logic [NumRegs-1:0]                busy_q, busy_d;
  logic [IndexWidth-1:0]             sweep_idx;
  logic                              sweep, wr_block;
  logic [NumWritePorts-1:0]          wr_act;

  rf_clear_ctrl #(
    .NumRegs    (NumRegs),
    .IndexWidth (IndexWidth)
  ) u_clear (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .clear_req_i  (clearReq),
    .sweep_idx_o  (sweep_idx),
    .sweep_o      (sweep),
    .clear_busy_o (clearBusy),
    .clear_done_o (clearDone)
  );

  // Write ports and reserves are frozen for the whole sweep including DONE.
  assign wr_block = clearBusy | clearDone;
  assign wr_act   = wr_block ? '0 : writeEn;

  function automatic logic [NumWritePorts-1:0] wr_win(input logic [IndexWidth-1:0] idx);
    logic [MaxWritePorts-1:0] hit;
    hit = '0;
    for (int p = 0; p < NumWritePorts; p++) hit[p] = wr_act[p] && (writeAddr[p] == idx);
    return NumWritePorts'(win_port(hit));
  endfunction

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin : next_state
    logic [NumWritePorts-1:0] win;
    win    = '0;
    regs_d = regs_q;
    busy_d = busy_q;
    if (sweep) begin
      regs_d[sweep_idx] = '0;
      busy_d[sweep_idx] = 1'b0;
    end else if (!wr_block) begin
      for (int r = 0; r < NumRegs; r++) begin
        win = wr_win(IndexWidth'(r));
        for (int p = 0; p < NumWritePorts; p++) begin
          if (win[p]) begin
            regs_d[r] = writeData[p];
            if (writeRelease[p]) busy_d[r] = 1'b0;
          end
        end
      end
      // Reserve is applied after release so it wins on the same register.
      if (reserveEn) busy_d[reserveAddr] = 1'b1;
    end
    if (ZeroReg != 0) begin
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
    end
  end

  always_comb begin : read_mux
    logic [NumWritePorts-1:0] rwin;
    rwin     = '0;
    readData = '0;
    readBusy = '0;
    for (int j = 0; j < NumReadPorts; j++) begin
      rwin        = wr_win(readAddr[j]);
      readData[j] = regs_q[readAddr[j]];
      readBusy[j] = busy_q[readAddr[j]];
      if (BypassEn != 0) begin
        for (int p = 0; p < NumWritePorts; p++) begin
          if (rwin[p]) begin
            readData[j] = writeData[p];
            if (writeRelease[p]) readBusy[j] = 1'b0;
          end
        end
      end
      if ((ZeroReg != 0) && (readAddr[j] == '0)) begin
        readData[j] = '0;
        readBusy[j] = 1'b0;
      end
      if (!rstN) begin
        readData[j] = '0;
        readBusy[j] = 1'b0;
      end
    end
  end

endmodule
